// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer: runs complete multi-byte full-duplex SPI transactions
// against the 8-bit SPI master core's register port. Slave select stays
// asserted across all bytes, and only one byte is ever in flight. Every core
// access lasts exactly two cycles, with at least one idle cycle between accesses.
module spi_txn_sequencer #(
  parameter int NUM_SS   = 1,
  parameter int POLL_MAX = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_len,
  input  logic [NUM_SS-1:0] cmd_ss,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              done,
  output logic              error,
  output logic              busy,
  output logic              spi_select,
  output logic              read_n,
  output logic              write_n,
  output logic [2:0]        mem_addr,
  output logic [15:0]       data_from_cpu,
  input  logic [15:0]       data_to_cpu
);

  localparam int PW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEL_WR, S_SSO_ON, S_POLL_T, S_TX_WAIT, S_DATA_WR, S_POLL_R,
    S_DATA_RD, S_RX_HOLD, S_POLL_E, S_ERR_CLR, S_SSO_OFF, S_DONE
  } state_t;

  state_t            state;
  state_t            poll_next;
  logic [1:0]        phase;      // 0: no access, 1: first strobe cycle, 2: second
  logic [7:0]        cnt;
  logic [NUM_SS-1:0] ss;
  logic [7:0]        tx_byte;
  logic [PW-1:0]     poll_cnt;
  logic              is_poll;
  logic              poll_hit;
  logic              stat_err;
  logic              poll_last;
  logic              acc_end;
  logic              acc_req;
  logic              acc_wr;
  logic [2:0]        acc_addr;
  logic [15:0]       acc_data;
  logic              status_unused;

  // Status bits that no state ever examines.
  assign status_unused = ^{data_to_cpu[15:8], data_to_cpu[2:0]};

  // A byte is taken from the client only while waiting for it.
  assign tx_ready = (state == S_TX_WAIT) && tx_valid;

  // Decode which status bit the current poll state is waiting on.
  always_comb begin
    is_poll   = 1'b0;
    poll_hit  = 1'b0;
    poll_next = state;
    case (state)
      S_POLL_T: begin is_poll = 1'b1; poll_hit = data_to_cpu[6]; poll_next = S_TX_WAIT; end
      S_POLL_R: begin is_poll = 1'b1; poll_hit = data_to_cpu[7]; poll_next = S_DATA_RD; end
      S_POLL_E: begin is_poll = 1'b1; poll_hit = data_to_cpu[5]; poll_next = S_SSO_OFF; end
      default:  begin is_poll = 1'b0; poll_hit = 1'b0; poll_next = state; end
    endcase
    stat_err  = data_to_cpu[3] | data_to_cpu[4];
    poll_last = (poll_cnt == PW'(POLL_MAX - 1));
    acc_end   = (phase == 2'd2);
  end

  // Select the core register access each state needs.
  always_comb begin
    acc_req  = 1'b1;
    acc_wr   = 1'b1;
    acc_addr = 3'd0;
    acc_data = 16'h0000;
    case (state)
      S_SEL_WR:  begin acc_addr = 3'd5; acc_data = 16'(ss); end
      S_SSO_ON:  begin acc_addr = 3'd3; acc_data = 16'h0400; end
      S_DATA_WR: begin acc_addr = 3'd1; acc_data = {8'h00, tx_byte}; end
      S_POLL_T, S_POLL_R, S_POLL_E: begin acc_wr = 1'b0; acc_addr = 3'd2; end
      S_DATA_RD: begin acc_wr = 1'b0; acc_addr = 3'd0; end
      S_ERR_CLR: begin acc_addr = 3'd2; acc_data = 16'h0000; end
      S_SSO_OFF: begin acc_addr = 3'd3; acc_data = 16'h0000; end
      default:   begin acc_req = 1'b0; acc_wr = 1'b0; end
    endcase
  end

  // Transaction FSM together with the two-cycle bus access engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      phase         <= 2'd0;
      cnt           <= 8'd0;
      ss            <= '0;
      tx_byte       <= 8'h00;
      poll_cnt      <= '0;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= 8'h00;
      spi_select    <= 1'b0;
      read_n        <= 1'b1;
      write_n       <= 1'b1;
      mem_addr      <= 3'd0;
      data_from_cpu <= 16'h0000;
    end else begin
      done <= 1'b0;
      if (!is_poll) poll_cnt <= '0;

      if (phase == 2'd0) begin
        if (acc_req) begin
          spi_select    <= 1'b1;
          mem_addr      <= acc_addr;
          data_from_cpu <= acc_data;
          write_n       <= ~acc_wr;
          read_n        <= acc_wr;
          phase         <= 2'd1;
        end
      end else if (phase == 2'd1) begin
        phase <= 2'd2;
      end else begin
        spi_select <= 1'b0;
        read_n     <= 1'b1;
        write_n    <= 1'b1;
        phase      <= 2'd0;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cnt       <= cmd_len;
            ss        <= cmd_ss;
            error     <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len == 8'd0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_SEL_WR;
            end
          end
        end
        S_SEL_WR:  if (acc_end) state <= S_SSO_ON;
        S_SSO_ON:  if (acc_end) state <= S_POLL_T;
        S_POLL_T, S_POLL_R, S_POLL_E: begin
          if (acc_end) begin
            if (stat_err) begin
              error <= 1'b1;
              state <= S_ERR_CLR;
            end else if (poll_hit) begin
              state <= poll_next;
            end else if (poll_last) begin
              error <= 1'b1;
              state <= S_SSO_OFF;
            end else begin
              poll_cnt <= poll_cnt + PW'(1);
            end
          end
        end
        S_TX_WAIT: begin
          if (tx_valid) begin
            tx_byte <= tx_data;
            state   <= S_DATA_WR;
          end
        end
        S_DATA_WR: if (acc_end) state <= S_POLL_R;
        S_DATA_RD: begin
          if (acc_end) begin
            rx_data  <= data_to_cpu[7:0];
            rx_valid <= 1'b1;
            state    <= S_RX_HOLD;
          end
        end
        S_RX_HOLD: begin
          if (rx_ready) begin
            rx_valid <= 1'b0;
            cnt      <= cnt - 8'd1;
            state    <= (cnt == 8'd1) ? S_POLL_E : S_POLL_T;
          end
        end
        S_ERR_CLR: if (acc_end) state <= S_SSO_OFF;
        S_SSO_OFF: begin
          if (acc_end) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a behavioural SPI core register model
// that loops MOSI back to MISO and logs every completed write access.
`timescale 1ns/1ps
module tb_spi_txn_sequencer;

  localparam int POLL_MAX = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid, cmd_ready, tx_valid, tx_ready, rx_valid, rx_ready;
  logic        done, error, busy, spi_select, read_n, write_n;
  logic [7:0]  cmd_len, tx_data, rx_data;
  logic [0:0]  cmd_ss;
  logic [2:0]  mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;

  spi_txn_sequencer #(.NUM_SS(1), .POLL_MAX(POLL_MAX)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_ss(cmd_ss), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .done(done), .error(error), .busy(busy), .spi_select(spi_select),
    .read_n(read_n), .write_n(write_n), .mem_addr(mem_addr),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- core register model ----------------
  logic [7:0]  m_rxd, m_txd;
  logic        m_rrdy, m_trdy, m_tmt, m_roe, m_toe;
  logic [15:0] m_ctrl;
  logic [3:0]  m_xfer;
  logic        stuck_trdy = 1'b0;
  logic [2:0]  a_addr;
  logic [15:0] a_data;
  logic        a_wr;
  int          low_cnt = 0;
  logic [2:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int stat_reads = 0, sel_cycles = 0, prot_err = 0, done_cnt = 0, sso_off_xfers = 0;

  assign data_to_cpu = (mem_addr == 3'd0) ? {8'h00, m_rxd} :
                       (mem_addr == 3'd2) ? {8'h00, m_rrdy, m_trdy & ~stuck_trdy, m_tmt, m_toe, m_roe, 3'b000} :
                       16'h0000;

  always @(posedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (spi_select === 1'b1) sel_cycles <= sel_cycles + 1;
    if (reset) begin
      m_rxd <= 8'h00; m_txd <= 8'h00; m_rrdy <= 1'b0; m_trdy <= 1'b1; m_tmt <= 1'b1;
      m_roe <= 1'b0; m_toe <= 1'b0; m_ctrl <= 16'h0000; m_xfer <= 4'd0; low_cnt <= 0;
    end else begin
      if (m_xfer != 4'd0) begin
        m_xfer <= m_xfer - 4'd1;
        if (m_xfer == 4'd1) begin
          m_rxd <= m_txd;
          if (m_rrdy) m_roe <= 1'b1;
          m_rrdy <= 1'b1; m_trdy <= 1'b1; m_tmt <= 1'b1;
        end
      end
      if (!read_n || !write_n) begin
        if (!spi_select || (!read_n && !write_n)) prot_err <= prot_err + 1;
        if (low_cnt == 0) begin
          a_addr <= mem_addr; a_data <= data_from_cpu; a_wr <= !write_n;
        end else if (mem_addr !== a_addr || data_from_cpu !== a_data || (!write_n) !== a_wr) begin
          prot_err <= prot_err + 1;
        end
        low_cnt <= low_cnt + 1;
      end else if (low_cnt != 0) begin
        low_cnt <= 0;
        if (low_cnt != 2) prot_err <= prot_err + 1;
        if (a_wr) begin
          wr_addr_q.push_back(a_addr);
          wr_data_q.push_back(a_data);
          case (a_addr)
            3'd1: begin
              if (!m_trdy) m_toe <= 1'b1;
              if (!m_ctrl[10]) sso_off_xfers <= sso_off_xfers + 1;
              m_txd <= a_data[7:0]; m_trdy <= 1'b0; m_tmt <= 1'b0; m_xfer <= 4'd6;
            end
            3'd2: begin m_roe <= 1'b0; m_toe <= 1'b0; end
            3'd3: m_ctrl <= a_data;
            default: ;
          endcase
        end else begin
          if (a_addr == 3'd2) stat_reads <= stat_reads + 1;
          if (a_addr == 3'd0) m_rrdy <= 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] txb[4];

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {23'd0, spi_select, read_n, write_n, cmd_ready, tx_ready,
                             rx_valid, done, error, busy}, 32'h0000_00E0);
    check_eq({tag, "_addr"}, {29'd0, mem_addr}, 32'd0);
    check_eq({tag, "_wdata"}, {16'd0, data_from_cpu}, 32'd0);
    check_eq({tag, "_rxdata"}, {24'd0, rx_data}, 32'd0);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [2:0] addr, input logic [15:0] data);
    logic [18:0] got;
    got = 19'h7FFFF;
    if (idx < wr_addr_q.size()) got = {wr_addr_q[idx], wr_data_q[idx]};
    check_eq(tag, {13'd0, got}, {13'd0, addr, data});
  endtask

  task automatic send_cmd(input logic [7:0] len);
    int k;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    check_eq("cmd_ready_wait", {31'd0, k < 100}, 32'd1);
    cmd_valid = 1'b1; cmd_len = len; cmd_ss = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_bytes(input int len, input int stall_idx, input string tag);
    int k;
    logic [7:0] hold;
    logic stable;
    for (int i = 0; i < len; i++) begin
      tx_valid = 1'b1; tx_data = txb[i]; k = 0;
      while (tx_ready !== 1'b1 && k < 500) begin @(negedge clk); k++; end
      check_eq({tag, "_tx_hs"}, {31'd0, k < 500}, 32'd1);
      @(negedge clk);
      tx_valid = 1'b0; tx_data = 8'h00; k = 0;
      while (rx_valid !== 1'b1 && k < 500) begin @(negedge clk); k++; end
      check_eq({tag, "_rx_wait"}, {31'd0, k < 500}, 32'd1);
      if (i == stall_idx) begin
        hold = rx_data; stable = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (rx_valid !== 1'b1 || rx_data !== hold) stable = 1'b0;
        end
        check_eq({tag, "_stall_hold"}, {31'd0, stable}, 32'd1);
      end
      check_eq({tag, "_rx"}, {24'd0, rx_data}, {24'd0, txb[i]});
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag, input logic exp_err);
    int k;
    int base;
    base = done_cnt; k = 0;
    while (done !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    check_eq({tag, "_done_seen"}, {31'd0, k < 1000}, 32'd1);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_done_cnt"}, done_cnt - base, 32'd1);
    check_eq({tag, "_error"}, {31'd0, error}, {31'd0, exp_err});
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int base_w, base_s, k;
    cmd_valid = 1'b0; cmd_len = 8'd0; cmd_ss = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("idle");
    check_eq("idle_no_select", sel_cycles, 32'd0);

    // single byte loopback
    base_w = wr_addr_q.size();
    txb[0] = 8'hA5;
    send_cmd(8'd1);
    check_eq("t1_busy", {30'd0, busy, cmd_ready}, 32'd2);
    run_bytes(1, -1, "t1");
    wait_done("t1", 1'b0);
    check_eq("t1_nwr", wr_addr_q.size() - base_w, 32'd4);
    check_wr("t1_wr0", base_w + 0, 3'd5, 16'h0001);
    check_wr("t1_wr1", base_w + 1, 3'd3, 16'h0400);
    check_wr("t1_wr2", base_w + 2, 3'd1, 16'h00A5);
    check_wr("t1_wr3", base_w + 3, 3'd3, 16'h0000);

    // four bytes, client stalls on the second
    base_w = wr_addr_q.size();
    txb[0] = 8'h01; txb[1] = 8'h02; txb[2] = 8'h03; txb[3] = 8'h04;
    send_cmd(8'd4);
    run_bytes(4, 1, "t2");
    wait_done("t2", 1'b0);
    check_eq("t2_nwr", wr_addr_q.size() - base_w, 32'd7);
    check_wr("t2_wr_ss", base_w + 0, 3'd5, 16'h0001);
    check_wr("t2_wr_on", base_w + 1, 3'd3, 16'h0400);
    for (int i = 0; i < 4; i++) check_wr("t2_wr_data", base_w + 2 + i, 3'd1, {8'h00, txb[i]});
    check_wr("t2_wr_off", base_w + 6, 3'd3, 16'h0000);
    check_eq("t2_sso_held", sso_off_xfers, 32'd0);

    // zero-length command
    base_w = wr_addr_q.size();
    base_s = sel_cycles;
    send_cmd(8'd0);
    k = 0;
    while (done !== 1'b1 && k < 3) begin @(negedge clk); k++; end
    check_eq("t3_done_fast", {31'd0, k < 3}, 32'd1);
    repeat (4) @(negedge clk);
    check_eq("t3_no_bus", sel_cycles - base_s, 32'd0);
    check_eq("t3_no_wr", wr_addr_q.size() - base_w, 32'd0);

    // TRDY never rises: poll timeout abort
    stuck_trdy = 1'b1;
    base_w = wr_addr_q.size();
    base_s = stat_reads;
    send_cmd(8'd1);
    wait_done("t4", 1'b1);
    check_eq("t4_polls", stat_reads - base_s, POLL_MAX);
    check_eq("t4_nwr", wr_addr_q.size() - base_w, 32'd3);
    check_wr("t4_wr_off", base_w + 2, 3'd3, 16'h0000);
    stuck_trdy = 1'b0;
    txb[0] = 8'h3C;
    send_cmd(8'd1);
    check_eq("t4_err_clear", {31'd0, error}, 32'd0);
    run_bytes(1, -1, "t4b");
    wait_done("t4b", 1'b0);

    // reset while polling RRDY on byte two
    base_w = wr_addr_q.size();
    txb[0] = 8'h11;
    send_cmd(8'd2);
    run_bytes(1, -1, "t5");
    tx_valid = 1'b1; tx_data = 8'h22; k = 0;
    while (tx_ready !== 1'b1 && k < 500) begin @(negedge clk); k++; end
    @(negedge clk);
    tx_valid = 1'b0; tx_data = 8'h00; k = 0;
    while (!(read_n === 1'b0 && mem_addr === 3'd2) && k < 500) begin @(negedge clk); k++; end
    check_eq("t5_reach_poll", {31'd0, k < 500}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5_no_sso_clr", wr_addr_q.size() - base_w, 32'd4);
    base_w = wr_addr_q.size();
    txb[0] = 8'h5A;
    send_cmd(8'd1);
    run_bytes(1, -1, "t5b");
    wait_done("t5b", 1'b0);
    check_wr("t5b_wr_data", base_w + 2, 3'd1, 16'h005A);
    check_wr("t5b_wr_off", base_w + 3, 3'd3, 16'h0000);

    check_eq("bus_protocol", prot_err, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Master-side sequencer that drives the 8-bit SPI master core through its 3-bit register port.
- Runs complete multi-byte, full-duplex transactions with slave select held across all bytes, so the CPU no longer polls status per byte.
- Sits between a command/byte-stream client (DMA or a small FSM) and the SPI core's register port; one transaction at a time.

Parameters:
- NUM_SS, 1, slave-select width; written zero-extended to 16 bits.
- POLL_MAX, 1023, maximum status reads per wait phase before the error abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  transaction request
- cmd_ready  out  1  high only in IDLE
- cmd_len  in  8  byte count; 0 means no SPI activity
- cmd_ss  in  NUM_SS  slave-select mask for this transaction
- tx_data  in  8  next MOSI byte
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  tx byte accepted this cycle
- rx_data  out  8  received MISO byte
- rx_valid  out  1  rx_data valid; held until rx_ready
- rx_ready  in  1  client accepts rx_data
- done  out  1  one-cycle pulse at transaction end
- error  out  1  sticky; cleared on next command acceptance
- busy  out  1  high whenever not IDLE
- spi_select  out  1  core chip select
- read_n  out  1  core read strobe, active low
- write_n  out  1  core write strobe, active low
- mem_addr  out  3  core register address
- data_from_cpu  out  16  core write data
- data_to_cpu  in  16  core read data

Behaviour:
- Reset values: spi_select=0, read_n=1, write_n=1, mem_addr=0, data_from_cpu=0, cmd_ready=1, tx_ready=0, rx_valid=0, rx_data=0, done=0, error=0, busy=0. State returns to IDLE.
- Reset mid-transaction aborts immediately; no SSO-clear write is issued. The core is on the same reset.
- Bus access, every one exactly 2 cycles: spi_select=1, mem_addr and data held stable, read_n or write_n low.
  - Read data is sampled from data_to_cpu on the clock edge that ends cycle 2.
  - Strobes deassert for at least 1 cycle between accesses.
- Core register map: addr 0 = rx data; 1 = tx data; 2 = status; 3 = control; 5 = slave select.
- Status bits: ROE=3, TOE=4, TMT=5, TRDY=6, RRDY=7. Control SSO = bit 10.
- Command acceptance: on cmd_valid & cmd_ready, latch cmd_len and cmd_ss into cnt and ss, clear error.
  - cmd_len=0 goes straight to DONE; no bus access is made.
- FSM states and transitions:
  - IDLE -> SEL_WR: write addr5 = {0, ss}.
  - SEL_WR -> SSO_ON: write addr3 = 16'h0400; all interrupt enables 0.
  - SSO_ON -> POLL_T: read addr2 repeatedly until TRDY=1.
  - POLL_T -> TX_WAIT: wait for tx_valid. tx_ready is a 1-cycle pulse when tx_valid=1; latch tx_data on that cycle.
  - TX_WAIT -> DATA_WR: write addr1 = {8'h00, byte}.
  - DATA_WR -> POLL_R: read addr2 until RRDY=1.
  - POLL_R -> DATA_RD: read addr0; rx_data = data_to_cpu[7:0]; set rx_valid.
  - DATA_RD -> RX_HOLD: hold rx_valid until rx_ready, then decrement cnt.
  - RX_HOLD -> POLL_T if cnt != 0; -> POLL_E if cnt = 0.
  - POLL_E: read addr2 until TMT=1.
  - POLL_E -> SSO_OFF: write addr3 = 16'h0000.
  - SSO_OFF -> DONE: pulse done for 1 cycle.
  - DONE -> IDLE.
- Single-buffered operation: exactly one byte is in flight, so ROE and TOE must never set.
  - Any status read with ROE or TOE set: error=1, write addr2 (clears core status), then SSO_OFF, DONE.
- Poll counter: reset on entry to each poll state, incremented per status read.
  - Reaching POLL_MAX reads without the awaited bit: error=1, go to SSO_OFF, then DONE.
  - done still pulses on an error abort.
- rx_valid never drops without rx_ready (stall indefinitely; there is no timeout on the client side).
- cmd_valid while busy is ignored; cmd_ready=0.

Test Plan:
- Reset, then 3 idle cycles -> outputs at listed reset values, cmd_ready=1, no spi_select activity.
- cmd_len=1, cmd_ss=1, tx 8'hA5, core model loops MOSI to MISO -> bus writes in order: addr5 0x0001, addr3 0x0400, addr1 0x00A5, addr3 0x0000; rx_data=8'hA5; one done pulse; error=0.
- cmd_len=4, tx 01,02,03,04; rx_ready low 20 cycles on byte 2 -> rx 01..04 in order; rx_valid held stable during the stall; exactly 4 addr1 writes; SS_n low continuously from the first to the last byte.
- cmd_len=0 -> done pulses within 3 cycles, zero bus accesses.
- Core status forced to TRDY=0, POLL_MAX=8 -> 8 addr2 reads, error=1, addr3 0x0000 write, done pulses; next command clears error.
- Reset asserted in POLL_R of byte 2 -> next cycle: state IDLE, all outputs at reset values; a subsequent cmd_len=1 completes normally.
